pc_trace: RTL
=============

# pc_trace

Branch-trace recorder that sits directly downstream of the `yfcpu` core and consumes its 8-bit `pc` output every clock. Sequential PC steps (pc+1, including wrap 0xFF→0x00) are ignored. Every discontinuity (jump, branch, reset-vector re-entry) is pushed as a {from, to} pair into an internal FIFO that the bench or a debug port drains with a request/valid handshake. It also flags a halted core (PC frozen).

## Interface
- PC_W, 8, width of the program counter.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- HALT_CYC, 4, consecutive unchanged-PC compares that assert `halted`; ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  PC_W  program counter from `yfcpu`, sampled every edge.
- trace_en  in  1  1 = record discontinuities; 0 = record nothing.
- clr  in  1  synchronous flush: empties the FIFO and clears `overflow`; PC tracking is not disturbed.
- rd_req  in  1  pop request.
- rd_data  out  2*PC_W  popped entry, {from[2*PC_W-1:PC_W], to[PC_W-1:0]}.
- rd_valid  out  1  one-cycle strobe qualifying `rd_data`.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one event was dropped.
- halted  out  1  PC frozen for ≥HALT_CYC compares.

## Operation
- State: `prev_pc` (PC_W), `primed` (1), FIFO storage with rd/wr pointers and occupancy, `hold_cnt` (saturating), output registers.
- Each edge with `rst`=0: if `primed`=0, load `prev_pc`←pc, set `primed`, no compare. Otherwise compare pc with `prev_pc`, then `prev_pc`←pc.
- Compare outcomes: pc == prev_pc+1 (mod 2^PC_W) → sequential, no event. pc == prev_pc → hold, no event. Anything else → event {prev_pc, pc}.
- Events are pushed only if `trace_en`=1. `prev_pc` updates regardless of `trace_en`, so re-enabling never fabricates a jump.
- Push accepted when count<DEPTH, or when count==DEPTH and a pop happens on the same edge. Otherwise the event is dropped and `overflow`←1.
- Pop: `rd_req`=1 with count>0 → head entry to `rd_data`, `rd_valid`←1, advance read pointer. `rd_req` while empty is ignored: `rd_valid`=0, `rd_data` holds.
- Simultaneous push and pop: count unchanged, both pointers advance. When empty, a same-edge push is not visible to that pop; the pop is ignored.
- `clr`: pointers and count←0, `overflow`←0. An event on the same edge is discarded. A `rd_req` on the same edge is ignored. `clr` has priority over push and pop.
- Halt: on a hold compare, `hold_cnt` increments (saturating at HALT_CYC). On a non-hold compare, it clears to 0. `halted` = (hold_cnt ≥ HALT_CYC), registered. Halt detection is independent of `trace_en` and `clr`.
- Pointers wrap modulo DEPTH. count/full/empty are registered, derived from the same edge's update.

## Timing
- Reset values: prev_pc=0, primed=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0, halted=0, hold_cnt=0. `rst` overrides `clr`, `rd_req`, push.
- Reset mid-operation discards all FIFO contents. The first post-reset edge only primes, so the CPU's reset jump to 0x00 is never logged.
- Event latency: a discontinuity seen at edge k is in the FIFO, and reflected in count/empty/full, after edge k.
- Read latency: `rd_req` high at edge k → `rd_data`/`rd_valid` valid after edge k for exactly one cycle. Back-to-back `rd_req` yields one entry per cycle.
- `halted` rises after the HALT_CYC-th consecutive hold compare. It falls after the first edge where pc differs.

## Test plan
- Reset, then pc 0x00,01,02,03 → no events, empty=1, count=0, halted=0.
- pc 0x05,0x06,0x20,0x21 with trace_en=1, then rd_req one cycle → rd_valid pulse, rd_data=0x0620, empty=1 afterwards.
- pc 0xFE,0xFF,0x00,0x01 → no event (wrap is sequential). pc 0x10 held for 4 edges with HALT_CYC=4 → halted=1 after the 4th hold. Next pc 0x11 → halted=0, no event.
- Generate 17 distinct jumps with DEPTH=16 and no reads → full=1, count=16, overflow=1. Drain → 16 entries in order, the 17th absent. clr → overflow=0.
- With FIFO full, a jump on the same edge as rd_req → count stays 16, overflow stays 0, new entry appears last on drain.
- trace_en=0 across jump 0x30→0x80, then re-enable with pc 0x81 → no entries. Assert rst while count=5 → count=0, empty=1, rd_valid=0, next edge only primes.

Source files
------------

// File: rtl/pc_trace.sv
// pc_trace: branch-trace recorder for the yfcpu program counter.
//
// Watches the core's PC on every clock edge. Sequential steps (pc+1, with
// wrap) and holds (pc unchanged) are not recorded; any other change is a
// discontinuity and is pushed as a {from, to} pair into a small FIFO that a
// debug port drains with a request/valid handshake. A run of unchanged PCs
// is reported as a halted core.
//
// Ports
//   clk       in   system clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   pc        in   PC_W  program counter sampled every edge
//   trace_en  in   1 = record discontinuities
//   clr       in   synchronous FIFO flush, also clears overflow
//   rd_req    in   pop request
//   rd_data   out  2*PC_W  popped entry {from, to}
//   rd_valid  out  one-cycle strobe qualifying rd_data
//   empty     out  FIFO holds no entries
//   full      out  FIFO holds DEPTH entries
//   count     out  current occupancy
//   overflow  out  sticky: at least one event was dropped
//   halted    out  PC frozen for at least HALT_CYC compares
module pc_trace #(
  parameter int PC_W     = 8,
  parameter int DEPTH    = 16,
  parameter int HALT_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PC_W-1:0]          pc,
  input  logic                     trace_en,
  input  logic                     clr,
  input  logic                     rd_req,
  output logic [2*PC_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halted
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int HC_W = $clog2(HALT_CYC + 1);

  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEPTH);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(HALT_CYC);

  // Trace storage: no reset, so it maps onto block RAM.
  logic [2*PC_W-1:0] mem [DEPTH];

  logic [PC_W-1:0]   prev_pc_q;
  logic              primed_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              empty_q;
  logic              full_q;
  logic              overflow_q;
  logic [2*PC_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [HC_W-1:0]   hold_cnt_q;
  logic [HC_W-1:0]   hold_cnt_d;
  logic              halted_q;

  logic [PC_W-1:0]   seq_pc;
  logic              is_hold;
  logic              is_event;
  logic              push_req;
  logic              pop_ok;
  logic              push_ok;
  logic              drop;

  always_comb begin
    seq_pc   = prev_pc_q + PC_ONE;
    // Nothing is compared on the priming edge after reset.
    is_hold  = primed_q && (pc == prev_pc_q);
    is_event = primed_q && (pc != prev_pc_q) && (pc != seq_pc);

    // clr discards both the same-edge event and the same-edge pop.
    push_req = is_event && trace_en && !clr;
    pop_ok   = rd_req && !empty_q && !clr;
    // A full FIFO still accepts an event when a pop frees the slot on the
    // same edge; an empty FIFO never lets the pop see the same-edge push.
    push_ok  = push_req && (!full_q || pop_ok);
    drop     = push_req && !push_ok;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    hold_cnt_d = hold_cnt_q;
    if (primed_q) begin
      if (is_hold) begin
        if (hold_cnt_q != HC_MAX) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end else begin
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr_q] <= {prev_pc_q, pc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc_q  <= '0;
      primed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      hold_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      // PC tracking runs regardless of trace_en and clr, so re-enabling
      // the trace never reports a stale jump.
      prev_pc_q  <= pc;
      primed_q   <= 1'b1;
      hold_cnt_q <= hold_cnt_d;
      halted_q   <= (hold_cnt_d >= HC_MAX);

      if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        empty_q    <= 1'b1;
        full_q     <= 1'b0;
        overflow_q <= 1'b0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_ok;
        if (pop_ok) begin
          rd_data_q <= mem[rd_ptr_q];
          rd_ptr_q  <= rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
        count_q <= count_d;
        empty_q <= (count_d == '0);
        full_q  <= (count_d == CNT_MAX);
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign halted   = halted_q;

endmodule
